// File: rtl/secret_operand_feeder.sv
// Operand-preparation stage for the per-coefficient add/subtract ALU.
// Holds one public coefficient together with its multiples 2a, 3a and 4a, and streams the
// packed 4-bit two's-complement secret coefficients of a 64-bit word as sign-magnitude
// select codes, one per cycle, under a valid/ready handshake.
module secret_operand_feeder #(
    parameter int unsigned A_W    = 13,
    parameter int unsigned COEF_W = 4,
    parameter int unsigned N_COEF = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [A_W-1:0]           a_in,
    input  logic                     a_load,
    input  logic [N_COEF*COEF_W-1:0] s_word,
    input  logic                     s_load,
    output logic                     s_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [3:0]               s_out,
    output logic                     last_out,
    output logic [A_W-1:0]           a_out,
    output logic [A_W-1:0]           ax2_out,
    output logic [A_W-1:0]           ax3_out,
    output logic [A_W-1:0]           ax4_out,
    output logic                     err_range
);

    localparam int unsigned WORD_W = N_COEF * COEF_W;
    localparam int unsigned IDX_W  = (N_COEF > 1) ? $clog2(N_COEF) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_COEF - 1);

    typedef enum logic [0:0] {
        StIdle,
        StStream
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic [A_W-1:0]     a_q, a_d;
    logic [A_W-1:0]     ax2_q, ax2_d;
    logic [A_W-1:0]     ax3_q, ax3_d;
    logic [A_W-1:0]     ax4_q, ax4_d;
    logic               err_q, err_d;

    logic               at_last;
    logic               fire;
    logic               accept;
    logic [COEF_W-1:0]  nib;
    int                 nib_val;
    logic [3:0]         code;
    logic               nib_oor;

    // Handshake: a word may be taken while idle, or in the same cycle the last nibble leaves.
    always_comb begin
        out_valid = (state_q == StStream);
        at_last   = (idx_q == LAST_IDX);
        fire      = out_valid && out_ready;
        s_ready   = (state_q == StIdle) || (fire && at_last);
        accept    = s_load && s_ready;
        last_out  = out_valid && at_last;
    end

    // Select the current nibble and convert it to a clamped sign-magnitude code.
    always_comb begin
        nib     = word_q[int'(idx_q) * COEF_W +: COEF_W];
        nib_val = int'($signed(nib));
        nib_oor = 1'b0;
        code    = 4'b0000;
        if (nib_val > 4) begin
            nib_oor = 1'b1;
            code    = 4'b0100;
        end else if (nib_val < -4) begin
            nib_oor = 1'b1;
            code    = 4'b1100;
        end else if (nib_val < 0) begin
            code = {1'b1, 3'(-nib_val)};
        end else begin
            // Zero lands here, so a zero magnitude never carries the sign bit.
            code = {1'b0, 3'(nib_val)};
        end
        s_out = out_valid ? code : 4'b0000;
    end

    // Stream control: advance on fire, reload on accept (accept wins for back-to-back words).
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        err_d   = err_q;
        if (fire) begin
            if (nib_oor) begin
                err_d = 1'b1;
            end
            if (at_last) begin
                state_d = StIdle;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
        if (accept) begin
            word_d  = s_word;
            idx_d   = '0;
            state_d = StStream;
        end
    end

    // Multiples are only captured while idle so they stay stable for a whole stream.
    always_comb begin
        a_d   = a_q;
        ax2_d = ax2_q;
        ax3_d = ax3_q;
        ax4_d = ax4_q;
        if (a_load && (state_q == StIdle)) begin
            a_d   = a_in;
            ax2_d = a_in << 1;
            ax3_d = a_in + (a_in << 1);
            ax4_d = a_in << 2;
        end
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            word_q  <= '0;
            a_q     <= '0;
            ax2_q   <= '0;
            ax3_q   <= '0;
            ax4_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            a_q     <= a_d;
            ax2_q   <= ax2_d;
            ax3_q   <= ax3_d;
            ax4_q   <= ax4_d;
            err_q   <= err_d;
        end
    end

    assign a_out     = a_q;
    assign ax2_out   = ax2_q;
    assign ax3_out   = ax3_q;
    assign ax4_out   = ax4_q;
    assign err_range = err_q;

endmodule

// File: tb/tb_secret_operand_feeder.sv
// Self-checking bench for secret_operand_feeder: table-driven multiples and conversion codes,
// with a scoreboard queue of expected codes popped whenever the DUT hands one over.
module tb_secret_operand_feeder;

    localparam int A_W    = 13;
    localparam int COEF_W = 4;
    localparam int N_COEF = 16;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [A_W-1:0]           a_in;
    logic                     a_load;
    logic [N_COEF*COEF_W-1:0] s_word;
    logic                     s_load;
    logic                     s_ready;
    logic                     out_valid;
    logic                     out_ready;
    logic [3:0]               s_out;
    logic                     last_out;
    logic [A_W-1:0]           a_out;
    logic [A_W-1:0]           ax2_out;
    logic [A_W-1:0]           ax3_out;
    logic [A_W-1:0]           ax4_out;
    logic                     err_range;

    always #5 clk = ~clk;

    secret_operand_feeder #(
        .A_W    (A_W),
        .COEF_W (COEF_W),
        .N_COEF (N_COEF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a_in      (a_in),
        .a_load    (a_load),
        .s_word    (s_word),
        .s_load    (s_load),
        .s_ready   (s_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s_out     (s_out),
        .last_out  (last_out),
        .a_out     (a_out),
        .ax2_out   (ax2_out),
        .ax3_out   (ax3_out),
        .ax4_out   (ax4_out),
        .err_range (err_range)
    );

    typedef struct {
        logic [A_W-1:0] a;
        logic [A_W-1:0] x1;
        logic [A_W-1:0] x2;
        logic [A_W-1:0] x3;
        logic [A_W-1:0] x4;
    } mult_vec_t;

    typedef struct {
        logic [3:0] code;
        logic       oor;
    } conv_vec_t;

    typedef struct {
        logic [3:0] code;
        logic       last;
        logic       oor;
    } exp_t;

    mult_vec_t mtab[4];
    conv_vec_t ctab[16];  // indexed by nibble value
    exp_t      sbq[$];

    int   n_cmp = 0;
    int   n_bad = 0;
    int   vcount = 0;
    logic err_model = 1'b0;

    localparam logic [63:0] W1 = 64'h0000_0000_000C_F410;
    localparam logic [63:0] W2 = 64'h4444_4444_4444_4444;
    localparam logic [63:0] W3 = 64'hFEDC_BA98_7654_3210;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [63:0] w);
        logic [3:0] nb;
        for (int i = 0; i < N_COEF; i++) begin
            nb = w[i*COEF_W +: COEF_W];
            sbq.push_back('{code: ctab[nb].code, last: (i == N_COEF - 1), oor: ctab[nb].oor});
        end
    endtask

    // Sampled on the falling edge, when inputs driven after the rising edge are stable.
    task automatic monitor();
        exp_t e;
        if (rst) begin
            sbq.delete();
            err_model = 1'b0;
        end else begin
            check("err_range", err_range, err_model);
            if (out_valid) vcount++;
            if (!out_valid) check("last_out_idle", last_out, 1'b0);
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: got s_out %0h, required no output", s_out);
                end else begin
                    e = sbq.pop_front();
                    check("s_out", s_out, e.code);
                    check("last_out", last_out, e.last);
                    if (e.oor) err_model = 1'b1;
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int max_cycles);
        int k = 0;
        while (sbq.size() != 0 && k < max_cycles) begin
            step();
            k++;
        end
        if (sbq.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d codes pending, required 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_s_out"}, s_out, 4'h0);
        check({tag, "_last_out"}, last_out, 1'b0);
        check({tag, "_a_out"}, a_out, '0);
        check({tag, "_ax2_out"}, ax2_out, '0);
        check({tag, "_ax3_out"}, ax3_out, '0);
        check({tag, "_ax4_out"}, ax4_out, '0);
        check({tag, "_err_range"}, err_range, 1'b0);
        check({tag, "_s_ready"}, s_ready, 1'b1);
    endtask

    initial begin
        int  v0;
        bit  found;

        mtab[0] = '{13'h1FFF, 13'h1FFF, 13'h1FFE, 13'h1FFD, 13'h1FFC};
        mtab[1] = '{13'h0003, 13'h0003, 13'h0006, 13'h0009, 13'h000C};
        mtab[2] = '{13'h1000, 13'h1000, 13'h0000, 13'h1000, 13'h0000};
        mtab[3] = '{13'h0ABC, 13'h0ABC, 13'h1578, 13'h0034, 13'h0AF0};

        ctab[0]  = '{4'h0, 1'b0};
        ctab[1]  = '{4'h1, 1'b0};
        ctab[2]  = '{4'h2, 1'b0};
        ctab[3]  = '{4'h3, 1'b0};
        ctab[4]  = '{4'h4, 1'b0};
        ctab[5]  = '{4'h4, 1'b1};
        ctab[6]  = '{4'h4, 1'b1};
        ctab[7]  = '{4'h4, 1'b1};
        ctab[8]  = '{4'hC, 1'b1};
        ctab[9]  = '{4'hC, 1'b1};
        ctab[10] = '{4'hC, 1'b1};
        ctab[11] = '{4'hC, 1'b1};
        ctab[12] = '{4'hC, 1'b0};
        ctab[13] = '{4'hB, 1'b0};
        ctab[14] = '{4'hA, 1'b0};
        ctab[15] = '{4'h9, 1'b0};

        rst = 1'b1; a_in = '0; a_load = 1'b0; s_word = '0; s_load = 1'b0; out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        check_all_zero("reset");

        // Multiples from the table.
        for (int i = 0; i < 4; i++) begin
            a_in = mtab[i].a;
            a_load = 1'b1;
            step();
            a_load = 1'b0;
            #1;
            check("a_out", a_out, mtab[i].x1);
            check("ax2_out", ax2_out, mtab[i].x2);
            check("ax3_out", ax3_out, mtab[i].x3);
            check("ax4_out", ax4_out, mtab[i].x4);
        end

        // Plain conversion stream.
        v0 = vcount;
        out_ready = 1'b1;
        s_word = W1; s_load = 1'b1;
        push_word(W1);
        #1;
        check("conv_s_ready", s_ready, 1'b1);
        step();
        s_load = 1'b0;
        #1;
        check("conv_first_valid", out_valid, 1'b1);
        drain(40);
        check("conv_back_idle", out_valid, 1'b0);
        check("conv_valid_cycles", vcount - v0, 16);
        check("conv_err_clear", err_range, 1'b0);

        // Backpressure on cycles 2..4 of the stream.
        v0 = vcount;
        s_word = W1; s_load = 1'b1;
        push_word(W1);
        step();
        s_load = 1'b0;
        step();
        out_ready = 1'b0;
        #1;
        check("stall_hold_c2", s_out, 4'h1);
        step();
        #1;
        check("stall_hold_c3", s_out, 4'h1);
        step();
        #1;
        check("stall_hold_c4", s_out, 4'h1);
        step();
        out_ready = 1'b1;
        drain(40);
        check("stall_valid_cycles", vcount - v0, 19);

        // Back-to-back words, with a_load mid-stream that must be ignored.
        v0 = vcount;
        s_word = W1; s_load = 1'b1;
        push_word(W1);
        step();
        s_load = 1'b0;
        a_in = 13'h0555; a_load = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (last_out) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check("b2b_last_seen", found, 1'b1);
        s_word = W2; s_load = 1'b1;
        push_word(W2);
        #1;
        check("b2b_s_ready", s_ready, 1'b1);
        step();
        s_load = 1'b0;
        #1;
        check("b2b_no_bubble_valid", out_valid, 1'b1);
        check("b2b_no_bubble_s_out", s_out, 4'h4);
        drain(40);
        a_load = 1'b0;
        check("b2b_valid_cycles", vcount - v0, 32);
        check("b2b_a_out_stable", a_out, 13'h0ABC);
        check("b2b_ax4_out_stable", ax4_out, 13'h0AF0);

        // Full range of nibble values, including out-of-range ones.
        v0 = vcount;
        s_word = W3; s_load = 1'b1;
        push_word(W3);
        step();
        s_load = 1'b0;
        #1;
        check("range_err_before", err_range, 1'b0);
        drain(40);
        check("range_valid_cycles", vcount - v0, 16);
        check("range_err_set", err_range, 1'b1);
        step();
        step();
        step();
        check("range_err_sticky", err_range, 1'b1);

        // Reset in the middle of a stream, then a fresh word with a simultaneous a_load.
        s_word = W1; s_load = 1'b1;
        push_word(W1);
        step();
        s_load = 1'b0;
        repeat (7) step();
        check("mid_stream_valid", out_valid, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check_all_zero("mid_reset");
        s_word = W2; s_load = 1'b1;
        a_in = 13'h0003; a_load = 1'b1;
        push_word(W2);
        step();
        s_load = 1'b0;
        a_load = 1'b0;
        #1;
        check("post_reset_s_out", s_out, 4'h4);
        check("post_reset_a_out", a_out, 13'h0003);
        check("post_reset_ax3_out", ax3_out, 13'h0009);
        drain(40);
        check("post_reset_idle", out_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/secret_operand_feeder.md
Name: secret_operand_feeder

Overview:
- Operand-preparation stage placed directly upstream of the per-coefficient add/subtract ALU in the polynomial multiplier.
- Latches one 13-bit public coefficient and registers its multiples a, 2a, 3a and 4a, all mod 2^13.
- Unpacks 64-bit words of 4-bit two's-complement secret coefficients, converts each to the ALU's sign-magnitude select code, and streams one code per cycle under a valid/ready handshake.

Parameters:
- A_W, 13, width of the public coefficient and of all multiples.
- COEF_W, 4, bits per packed secret coefficient.
- N_COEF, 16, coefficients per packed word; the word is N_COEF*COEF_W = 64 bits wide.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- a_in  in  13  public coefficient.
- a_load  in  1  captures a_in; honoured only in IDLE.
- s_word  in  64  packed secret coefficients; nibble 0 is s_word[3:0], sent first.
- s_load  in  1  word-valid; the word is accepted when s_load && s_ready.
- s_ready  out  1  block can accept a word this cycle.
- out_valid  out  1  s_out and the multiples are valid.
- out_ready  in  1  consumer accepts the current s_out.
- s_out  out  4  bit 3 is the sign (1 means subtract), bits 2:0 are the magnitude 0..4.
- last_out  out  1  current s_out is nibble N_COEF-1 of its word.
- a_out, ax2_out, ax3_out, ax4_out  out  13 each  registered a, 2a, 3a, 4a mod 2^13.
- err_range  out  1  sticky flag: a nibble outside -4..4 was seen.

Behaviour:
- Reset, synchronous, takes priority over all other inputs, including mid-stream:
  - State goes to IDLE, nibble index to 0, the word register is cleared.
  - All outputs go to 0: out_valid, s_out, last_out, a_out, ax2_out, ax3_out, ax4_out, err_range.
  - s_ready reads 1 in the first cycle after reset.
- a_load in IDLE:
  - On the next edge, a_out = a_in, ax2_out = a_in<<1, ax3_out = a_in + (a_in<<1), ax4_out = a_in<<2.
  - All results are truncated to 13 bits.
  - a_load outside IDLE is ignored; the multiples stay stable for the whole stream.
- States:
  - IDLE: s_ready = 1, out_valid = 0.
  - STREAM: out_valid = 1.
- Word acceptance:
  - On s_load && s_ready, the word is latched, the index is set to 0, and the state goes to STREAM.
  - out_valid rises on the cycle after acceptance, so latency from load to first valid is 1 cycle.
  - If a_load and s_load are both asserted in IDLE, both are captured on the same edge.
- Advance:
  - In STREAM, out_valid && out_ready increments the index.
  - When out_ready = 0, s_out, last_out and the index hold.
- Last nibble:
  - When index = N_COEF-1 is accepted, the state returns to IDLE, unless a new word is accepted in that same cycle.
  - s_ready = IDLE || (STREAM && index==N_COEF-1 && out_ready).
  - On a back-to-back word: stay in STREAM, index to 0, no bubble.
- last_out = out_valid && index==N_COEF-1.
- Conversion of nibble n (combinational from the word register and index, so s_out is stable while held):
  - n in 0..4: s_out = {0, n[2:0]}.
  - n in 12..15 (-4..-1): s_out = {1, (-n)[2:0]}.
  - n in 5..7: s_out = 4'b0100 (clamped to +4).
  - n in 8..11: s_out = 4'b1100 (clamped to -4).
  - A zero magnitude never carries sign 1.
- err_range is set on the edge at which an out-of-range nibble is accepted (out_valid && out_ready). It is cleared only by rst.
- The block accumulates nothing. The downstream ALU takes Ri itself and selects from a/ax2/ax3/ax4 using s_out.

Test Plan:
- Multiples: rst, then a_load with a_in = 13'h1FFF in IDLE → next cycle a_out = 1FFF, ax2_out = 1FFE, ax3_out = 1FFD, ax4_out = 1FFC. Repeat with a_in = 13'h0003 → 0003, 0006, 0009, 000C.
- Conversion: s_word = 64'h0000_0000_000C_F410 with out_ready = 1 → s_out = 0, 1, 4, 9, C, then 0 eleven times. last_out is high only on the 16th code; out_valid is high for exactly 16 cycles; err_range stays 0.
- Backpressure: same word, with out_ready low on cycles 2–4 → s_out holds 1 during the stall. Total sequence unchanged, 19 cycles of out_valid.
- Back-to-back: second word 64'h4444_4444_4444_4444 asserted with s_load during the last-nibble cycle → s_ready = 1 that cycle and the next cycle shows s_out = 4 with no gap. a_load asserted mid-stream leaves a_out unchanged.
- Range: nibbles 5 and 8 in a word → s_out = 4 and C respectively. err_range rises when nibble 5 is accepted and stays 1 through IDLE until rst.
- Reset mid-stream: rst at index 7 → next cycle out_valid = 0, all outputs 0, s_ready = 1. A new word then streams from nibble 0.
